bus_xfer_unit: RTL

//  Parametrised successor to the processor's shared data bus. Moves one word per transfer from one
//  of N_SRC source registers (or an instruction constant) to any subset of N_DST destinations.

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_xfer_unit_if.sv | 32 +++
 rtl/bus_src_mux.sv | 32 +++
 rtl/bus_xfer_unit.sv | 79 +++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants and helpers for the bus transfer unit: source-select encoding,
// default bus reset value and the illegal-select check.
package bus_pkg;

   localparam int unsigned SRC_HOLD = 0;
   localparam int unsigned SRC_BASE = 1;

   localparam logic [15:0] RESET_VAL_DEFAULT = 16'h0007;

   // The constant-field code sits directly after the last register source.
   function automatic int unsigned src_const(input int unsigned n_src);
      return n_src + SRC_BASE;
   endfunction

   function automatic logic sel_is_illegal(input int unsigned sel, input int unsigned n_src);
      return sel > src_const(n_src);
   endfunction

endpackage

// File: rtl/bus_xfer_unit_if.sv
// Handshake and data signals between the control unit (master) and the bus transfer unit
// (slave); stall arrives from the destinations on the master side.
interface bus_xfer_unit_if #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned N_SRC   = 10,
   parameter int unsigned N_DST   = 4,
   parameter int unsigned CONST_W = 4,
   parameter int unsigned SEL_W   = 4
);

   logic [N_SRC*WIDTH-1:0] src_data;
   logic [CONST_W-1:0]     const_in;
   logic [SEL_W-1:0]       src_sel;
   logic [N_DST-1:0]       dst_mask;
   logic                   xfer_valid;
   logic                   xfer_ready;
   logic                   stall;
   logic [WIDTH-1:0]       bus_out;
   logic [N_DST-1:0]       dst_we;
   logic                   sel_err;

   modport master (
      output src_data, const_in, src_sel, dst_mask, xfer_valid, stall,
      input  xfer_ready, bus_out, dst_we, sel_err
   );

   modport slave (
      input  src_data, const_in, src_sel, dst_mask, xfer_valid, stall,
      output xfer_ready, bus_out, dst_we, sel_err
   );

endinterface

// File: rtl/bus_src_mux.sv
// Combinational source selection: register sources, zero-extended constant or the held bus word,
// plus a flag for select codes beyond the constant slot.
module bus_src_mux
   import bus_pkg::*;
#(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned N_SRC   = 10,
   parameter int unsigned CONST_W = 4,
   parameter int unsigned SEL_W   = 4
) (
   input  logic [N_SRC*WIDTH-1:0] src_data,
   input  logic [CONST_W-1:0]     const_in,
   input  logic [SEL_W-1:0]       src_sel,
   input  logic [WIDTH-1:0]       hold_word,
   output logic [WIDTH-1:0]       word,
   output logic                   illegal
);

   always_comb begin
      word    = hold_word;
      illegal = sel_is_illegal(32'(src_sel), N_SRC);
      if (src_sel == SEL_W'(src_const(N_SRC))) begin
         word = WIDTH'(const_in);
      end
      for (int k = 0; k < int'(N_SRC); k++) begin
         if (src_sel == SEL_W'(SRC_BASE + 32'(k))) begin
            word = src_data[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/bus_xfer_unit.sv
// Shared data bus: one word per accepted transfer into the bus register, multicast write strobes
// one cycle later, held while a destination stalls.
module bus_xfer_unit
   import bus_pkg::*;
#(
   parameter int unsigned     WIDTH     = 16,
   parameter int unsigned     N_SRC     = 10,
   parameter int unsigned     N_DST     = 4,
   parameter int unsigned     CONST_W   = 4,
   parameter int unsigned     SEL_W     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEFAULT)
) (
   input logic             clock,
   input logic             reset,
   bus_xfer_unit_if.slave  xfer
);

   logic [WIDTH-1:0] bus_q, bus_d;
   logic [N_DST-1:0] we_q, we_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] sel_word;
   logic             sel_illegal;
   logic             pending;
   logic             ready;
   logic             accept;

   bus_src_mux #(
      .WIDTH   (WIDTH),
      .N_SRC   (N_SRC),
      .CONST_W (CONST_W),
      .SEL_W   (SEL_W)
   ) u_src_mux (
      .src_data  (xfer.src_data),
      .const_in  (xfer.const_in),
      .src_sel   (xfer.src_sel),
      .hold_word (bus_q),
      .word      (sel_word),
      .illegal   (sel_illegal)
   );

   assign pending = |we_q;
   assign ready   = !(xfer.stall && pending);
   assign accept  = xfer.xfer_valid && ready;

   always_comb begin
      bus_d = bus_q;
      we_d  = '0;
      err_d = 1'b0;
      if (xfer.stall && pending) begin
         // Destination not ready: keep presenting the same word and strobes.
         we_d = we_q;
      end else if (accept) begin
         if (sel_illegal) begin
            err_d = 1'b1;
         end else begin
            bus_d = sel_word;
            we_d  = xfer.dst_mask;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus_q <= RESET_VAL;
         we_q  <= '0;
         err_q <= 1'b0;
      end else begin
         bus_q <= bus_d;
         we_q  <= we_d;
         err_q <= err_d;
      end
   end

   assign xfer.xfer_ready = ready;
   assign xfer.bus_out    = bus_q;
   assign xfer.dst_we     = we_q;
   assign xfer.sel_err    = err_q;

endmodule
